// File: rtl/knn_nat_reader.sv
// knn_nat_reader: native-bus read master that streams LEN words from BASE to the KNN datapath
// Ports:
//   clk, rst (async, active-low)         clock and reset
//   start, abort, base_addr, len         transfer control; base_addr/len sampled on accepted start
//   busy, done, aborted, xfer_cnt        status; done/aborted are one-cycle pulses after busy falls
//   m_valid, m_addr, m_wdata, m_wstrb    native request (read-only, wdata/wstrb tied to 0)
//   m_rdata, m_ready                     native single-cycle response
//   out_valid, out_data, out_ready       output stream from a 2-entry first-word-fall-through FIFO
module knn_nat_reader #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LEN_W-1:0]    xfer_cnt,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready
);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FLUSH} state_t;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  state_t state, state_next;
  logic [LEN_W-1:0] remaining;
  logic [DATA_W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count, lvl;
  logic abort_pend, abort_pend_next, m_valid_next, done_next, aborted_next;
  logic launch, resp, push, pop, flush;
  assign m_wdata = '0;
  assign m_wstrb = '0;
  assign busy = state != IDLE;
  // FLUSH discards the FIFO contents, so they must not be offered downstream meanwhile
  assign out_valid = count != 2'd0 && state != FLUSH;
  assign out_data = mem[rd_ptr];
  assign pop = out_valid && out_ready;
  assign resp = m_valid && m_ready;
  assign launch = state == IDLE && start && len != '0;
  // FIFO level after this cycle's pop; a new request needs a free slot for its response
  assign lvl = count - 2'(pop);
  always_comb begin
    state_next = state;
    m_valid_next = m_valid;
    abort_pend_next = abort_pend;
    done_next = 1'b0;
    aborted_next = 1'b0;
    push = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = len != '0 ? REQ : IDLE;
        m_valid_next = len != '0;
        done_next = len == '0;
      end
      REQ: if (resp) begin
        if (abort_pend || abort) begin
          state_next = FLUSH;
          m_valid_next = 1'b0;
          abort_pend_next = 1'b0;
        end else begin
          push = 1'b1;
          state_next = remaining == LEN_W'(1) ? DRAIN : REQ;
          m_valid_next = remaining != LEN_W'(1) && lvl == 2'd0;
        end
      end else if (m_valid) begin
        // an issued request cannot be withdrawn; remember the abort until its response arrives
        abort_pend_next = abort_pend || abort;
      end else if (abort) begin
        state_next = FLUSH;
      end else begin
        m_valid_next = lvl != 2'd2;
      end
      DRAIN: if (count == 2'd0) begin
        done_next = 1'b1;
        state_next = IDLE;
      end else if (abort) begin
        state_next = FLUSH;
      end
      FLUSH: begin
        flush = 1'b1;
        aborted_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      m_valid <= 1'b0;
      abort_pend <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      m_addr <= '0;
      remaining <= '0;
      xfer_cnt <= '0;
      count <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_next;
      m_valid <= m_valid_next;
      abort_pend <= abort_pend_next;
      done <= done_next;
      aborted <= aborted_next;
      if (launch) begin
        m_addr <= base_addr & ~(STEP - ADDR_W'(1));
        remaining <= len;
      end else if (push) begin
        m_addr <= m_addr + STEP;
        remaining <= remaining - LEN_W'(1);
      end
      if (state == IDLE && start) xfer_cnt <= '0;
      else if (pop) xfer_cnt <= xfer_cnt + LEN_W'(1);
      if (push) begin
        mem[wr_ptr] <= m_rdata;
        wr_ptr <= ~wr_ptr;
      end
      if (flush) begin
        count <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        count <= count + 2'(push) - 2'(pop);
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_knn_nat_reader.sv
// tb_knn_nat_reader: directed bench for knn_nat_reader with a delay-configurable memory slave
module tb_knn_nat_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic busy, done, aborted;
  logic [15:0] xfer_cnt;
  logic m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_wstrb;
  logic [31:0] m_rdata = '0;
  logic m_ready = 1'b0;
  logic out_valid;
  logic [31:0] out_data;
  logic out_ready = 1'b0;
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, abort_cnt = 0, mv_cnt = 0, rsp_idx = 0;
  int fixed_delay = 0, cur_delay = 0, wait_n = 0;
  bit rand_delay = 1'b0, armed = 1'b0;
  logic [31:0] data_base = '0, hold_addr = '0;
  logic [31:0] out_log[$], addr_log[$];

  always #5 clk = ~clk;

  knn_nat_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  // memory slave: answers each request after a fixed or random delay, data = data_base + response index
  always @(negedge clk) begin
    if (!rst) begin
      m_ready = 1'b0;
      armed = 1'b0;
    end else begin
      if (m_ready) begin
        m_ready = 1'b0;
        armed = 1'b0;
      end
      if (m_valid) begin
        if (!armed) begin
          armed = 1'b1;
          wait_n = 0;
          cur_delay = rand_delay ? int'($urandom_range(0, 5)) : fixed_delay;
          hold_addr = m_addr;
        end else begin
          vectors++;
          if (m_addr !== hold_addr) begin
            miscompares++;
            $display("FAIL addr_stable got %h exp %h", m_addr, hold_addr);
          end
        end
        if (wait_n >= cur_delay) begin
          m_ready = 1'b1;
          m_rdata = data_base + 32'(rsp_idx);
          rsp_idx++;
          addr_log.push_back(m_addr);
        end else begin
          wait_n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) out_log.push_back(out_data);
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
    if (m_valid) mv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_log.delete();
    addr_log.delete();
    rsp_idx = 0;
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] l);
    start = 1'b1;
    base_addr = b;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit, output bit ok);
    int d0 = done_cnt, a0 = abort_cnt;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != d0 || abort_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0 || aborted !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got done=%b aborted=%b exp 0 0", done, aborted); end
    vectors++; if (m_valid !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valids got m_valid=%b out_valid=%b exp 0 0", m_valid, out_valid); end
    vectors++; if (xfer_cnt !== 16'h0 || m_addr !== 32'h0) begin miscompares++; $display("FAIL reset_regs got xfer_cnt=%h m_addr=%h exp 0 0", xfer_cnt, m_addr); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int d0 = done_cnt;
    clear_logs();
    data_base = 32'hA0;
    fixed_delay = 0;
    out_ready = 1'b1;
    start_xfer(32'h100, 16'd4);
    vectors++; if (m_valid !== 1'b1 || m_addr !== 32'h100 || busy !== 1'b1) begin miscompares++; $display("FAIL basic_first_req got valid=%b addr=%h busy=%b exp 1 00000100 1", m_valid, m_addr, busy); end
    vectors++; if (m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin miscompares++; $display("FAIL basic_wr_tie got wdata=%h wstrb=%h exp 0 0", m_wdata, m_wstrb); end
    wait_end(100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout got no end exp done"); end
    vectors++; if (addr_log.size() != 4 || out_log.size() != 4) begin miscompares++; $display("FAIL basic_sizes got addr=%0d out=%0d exp 4 4", addr_log.size(), out_log.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (addr_log[i] !== 32'h100 + 32'(4 * i)) begin miscompares++; $display("FAIL basic_addr[%0d] got %h exp %h", i, addr_log[i], 32'h100 + 32'(4 * i)); end
      vectors++; if (out_log[i] !== 32'hA0 + 32'(i)) begin miscompares++; $display("FAIL basic_data[%0d] got %h exp %h", i, out_log[i], 32'hA0 + 32'(i)); end
    end
    vectors++; if (xfer_cnt !== 16'd4 || done_cnt != d0 + 1) begin miscompares++; $display("FAIL basic_end got xfer_cnt=%0d done_pulses=%0d exp 4 1", xfer_cnt, done_cnt - d0); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    data_base = 32'hB0;
    out_ready = 1'b0;
    start_xfer(32'h200, 16'd5);
    repeat (20) tick();
    vectors++; if (rsp_idx != 2 || m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_stall got reads=%0d m_valid=%b exp 2 0", rsp_idx, m_valid); end
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'hB0 || xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL bp_head got valid=%b data=%h cnt=%0d exp 1 000000b0 0", out_valid, out_data, xfer_cnt); end
    out_ready = 1'b1;
    wait_end(100, ok);
    vectors++; if (!ok || out_log.size() != 5) begin miscompares++; $display("FAIL bp_count got ended=%b words=%0d exp 1 5", ok, out_log.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (out_log[i] !== 32'hB0 + 32'(i) || addr_log[i] !== 32'h200 + 32'(4 * i)) begin miscompares++; $display("FAIL bp_word[%0d] got data=%h addr=%h exp %h %h", i, out_log[i], addr_log[i], 32'hB0 + 32'(i), 32'h200 + 32'(4 * i)); end
    end
    vectors++; if (xfer_cnt !== 16'd5) begin miscompares++; $display("FAIL bp_xfer_cnt got %0d exp 5", xfer_cnt); end
  endtask

  task automatic test_zero_wrap();
    bit ok;
    int mv0 = mv_cnt;
    clear_logs();
    start_xfer(32'h40, 16'd0);
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL zero_done got done=%b busy=%b exp 1 0", done, busy); end
    tick();
    vectors++; if (done !== 1'b0 || mv_cnt != mv0) begin miscompares++; $display("FAIL zero_quiet got done=%b m_valid_cycles=%0d exp 0 0", done, mv_cnt - mv0); end
    data_base = 32'hC0;
    start_xfer(32'hFFFF_FFFE, 16'd2);
    vectors++; if (m_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_align got %h exp fffffffc", m_addr); end
    wait_end(100, ok);
    vectors++; if (!ok || addr_log.size() != 2 || out_log.size() != 2) begin miscompares++; $display("FAIL wrap_sizes got ended=%b addr=%0d out=%0d exp 1 2 2", ok, addr_log.size(), out_log.size()); end
    vectors++; if (addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h %h exp fffffffc 00000000", addr_log[0], addr_log[1]); end
    vectors++; if (out_log[0] !== 32'hC0 || out_log[1] !== 32'hC1) begin miscompares++; $display("FAIL wrap_data got %h %h exp c0 c1", out_log[0], out_log[1]); end
  endtask

  task automatic test_abort_inflight();
    bit ok;
    int d0 = done_cnt, a0 = abort_cnt;
    clear_logs();
    data_base = 32'hD0;
    fixed_delay = 3;
    out_ready = 1'b1;
    start_xfer(32'h300, 16'd8);
    for (int i = 0; i < 20 && rsp_idx < 1; i++) tick();
    vectors++; if (rsp_idx != 1) begin miscompares++; $display("FAIL abort_first_rsp got %0d exp 1", rsp_idx); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL abort_hold0 got %b exp 1", m_valid); end
    tick();
    vectors++; if (m_valid !== 1'b1 || m_addr !== 32'h304) begin miscompares++; $display("FAIL abort_hold1 got valid=%b addr=%h exp 1 00000304", m_valid, m_addr); end
    wait_end(30, ok);
    vectors++; if (!ok || abort_cnt != a0 + 1 || done_cnt != d0) begin miscompares++; $display("FAIL abort_pulse got aborted=%0d done=%0d exp 1 0", abort_cnt - a0, done_cnt - d0); end
    vectors++; if (rsp_idx != 2) begin miscompares++; $display("FAIL abort_inflight_rsp got %0d exp 2", rsp_idx); end
    vectors++; if (out_log.size() != 1 || out_log[0] !== 32'hD0) begin miscompares++; $display("FAIL abort_words got n=%0d first=%h exp 1 000000d0", out_log.size(), out_log[0]); end
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0 || xfer_cnt !== 16'd1) begin miscompares++; $display("FAIL abort_idle got busy=%b out_valid=%b cnt=%0d exp 0 0 1", busy, out_valid, xfer_cnt); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    vectors++; if (abort_cnt != a0 + 1 || done_cnt != d0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle_ignored got aborted=%0d done=%0d busy=%b exp 1 0 0", abort_cnt - a0, done_cnt - d0, busy); end
    fixed_delay = 0;
  endtask

  task automatic test_slow_slave();
    int d0 = done_cnt;
    clear_logs();
    data_base = 32'h1000;
    rand_delay = 1'b1;
    start_xfer(32'h400, 16'd16);
    for (int i = 0; i < 600 && done_cnt == d0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      start = (i % 5 == 2) && busy && rsp_idx < 12;
      base_addr = 32'h0;
      len = 16'd3;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    rand_delay = 1'b0;
    vectors++; if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL slow_timeout got done_pulses=%0d exp 1", done_cnt - d0); end
    vectors++; if (out_log.size() != 16 || addr_log.size() != 16) begin miscompares++; $display("FAIL slow_sizes got out=%0d addr=%0d exp 16 16", out_log.size(), addr_log.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (out_log[i] !== 32'h1000 + 32'(i) || addr_log[i] !== 32'h400 + 32'(4 * i)) begin miscompares++; $display("FAIL slow_word[%0d] got data=%h addr=%h exp %h %h", i, out_log[i], addr_log[i], 32'h1000 + 32'(i), 32'h400 + 32'(4 * i)); end
    end
    vectors++; if (xfer_cnt !== 16'd16) begin miscompares++; $display("FAIL slow_xfer_cnt got %0d exp 16", xfer_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0 = done_cnt, a0 = abort_cnt;
    clear_logs();
    data_base = 32'hE0;
    fixed_delay = 2;
    out_ready = 1'b0;
    start_xfer(32'h500, 16'd6);
    repeat (4) tick();
    vectors++; if (m_valid !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre got m_valid=%b out_valid=%b busy=%b exp 1 1 1", m_valid, out_valid, busy); end
    rst = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_async got m_valid=%b out_valid=%b busy=%b exp 0 0 0", m_valid, out_valid, busy); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (done_cnt != d0 || abort_cnt != a0 || xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_no_pulse got done=%0d aborted=%0d cnt=%0d exp 0 0 0", done_cnt - d0, abort_cnt - a0, xfer_cnt); end
    clear_logs();
    data_base = 32'hF0;
    fixed_delay = 0;
    out_ready = 1'b1;
    abort = 1'b1;
    start_xfer(32'h600, 16'd1);
    abort = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_beats_abort got busy=%b exp 1", busy); end
    wait_end(50, ok);
    vectors++; if (!ok || done_cnt != d0 + 1 || abort_cnt != a0) begin miscompares++; $display("FAIL mid_restart got done=%0d aborted=%0d exp 1 0", done_cnt - d0, abort_cnt - a0); end
    vectors++; if (out_log.size() != 1 || out_log[0] !== 32'hF0 || addr_log[0] !== 32'h600 || xfer_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_word got n=%0d data=%h addr=%h cnt=%0d exp 1 f0 600 1", out_log.size(), out_log[0], addr_log[0], xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_wrap();
    test_abort_inflight();
    test_slow_slave();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
